// File: rtl/seg7_scan4_driver_if.sv
// Display-side bundle of the 4-digit seven-segment scanner: value/control inputs
// from the producer and the active-low digit, segment and decimal-point drives.
interface seg7_scan4_driver_if;
  logic [15:0] bcd;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output bcd, load, blank_lz, dp_en,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  bcd, load, blank_lz, dp_en,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan4_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with leading-zero
// blanking; new values are latched into the displayed word only at frame wrap.
module seg7_scan4_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input logic            clk,
  input logic            rst,
  seg7_scan4_driver_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_d;
  logic [15:0]      r_pend;
  logic             r_pend_v;
  logic [15:0]      r_shown;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_done;

  logic             w_tick;
  logic             w_wrap;
  logic [6:0]       w_dec [4];
  logic [3:0]       w_zero_up;
  logic             w_blank;
  logic [6:0]       w_seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'b0111111;
    case (nib)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign w_tick = (r_cnt == CNT_LAST);
  assign w_wrap = w_tick && (r_d == 2'd3);

  // w_zero_up[k]: nibbles k..3 of the shown word are all zero
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign w_dec[gi]     = seg_decode(r_shown[4*gi +: 4]);
    assign w_zero_up[gi] = ~|r_shown[15:4*gi];
  end

  assign w_blank    = bus.blank_lz && (r_d != 2'd0) && w_zero_up[r_d];
  assign w_seg_next = w_blank ? 7'b1111111 : w_dec[r_d];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_d          <= 2'd0;
      r_pend       <= 16'h0000;
      r_pend_v     <= 1'b0;
      r_shown      <= 16'h0000;
      r_an         <= 4'b1111;
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_d <= r_d + 2'd1;
      end

      // A load coinciding with wrap still lands in pend; shown takes the old pend.
      if (w_wrap && r_pend_v) begin
        r_shown <= r_pend;
      end
      if (bus.load) begin
        r_pend   <= bus.bcd;
        r_pend_v <= 1'b1;
      end else if (w_wrap) begin
        r_pend_v <= 1'b0;
      end

      r_an         <= ~(4'b0001 << r_d);
      r_seg        <= w_seg_next;
      r_dp         <= ~bus.dp_en[r_d];
      r_frame_done <= w_wrap;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule
